instr_mem_loader: RTL and testbench

Boot-time writer for the 32-bit instruction memory. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses through the memory's write port (write address, write data, write enable). The processor core is held in reset until a complete, valid image has been loaded. The core's fetch path is the only reader of what this block writes.

---
 rtl/instr_mem_loader_if.sv | 21 ++
 rtl/instr_mem_loader.sv | 99 +++++++++
 tb/tb_instr_mem_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input, instruction-memory write port and boot status
interface instr_mem_loader_if;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic [63:0] MEM_WADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_WR;
    logic        CORE_RST;
    logic        LOAD_DONE;
    logic        LOAD_ERR;
    logic [15:0] WORD_CNT;
    modport master (
        output BYTE_IN, BYTE_VALID,
        input  BYTE_READY, MEM_WADDR, MEM_WDATA, MEM_WR, CORE_RST, LOAD_DONE, LOAD_ERR, WORD_CNT
    );
    modport slave (
        input  BYTE_IN, BYTE_VALID,
        output BYTE_READY, MEM_WADDR, MEM_WDATA, MEM_WR, CORE_RST, LOAD_DONE, LOAD_ERR, WORD_CNT
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: framed byte stream -> 32-bit instruction memory writes; LOADER_CHECKSUM_EN adds a trailing checksum byte
module instr_mem_loader #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input logic CLK,
    input logic RST,
    instr_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR
    } state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CHECK;
`else
    localparam state_t FIN = DONE;
`endif
    state_t state, state_n;
    logic [1:0] bcnt;
    logic [15:0] len, widx, n_hdr;
    logic [23:0] asm_q;
    logic fire, word_end;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic last;
    assign last = widx == len - 16'd1;
`endif
    assign fire = bus.BYTE_VALID && bus.BYTE_READY;
    assign word_end = fire && state == DATA && bcnt == 2'd3;
    assign n_hdr = {bus.BYTE_IN, len[7:0]};

    // state register
    always_ff @(posedge CLK) state <= RST ? IDLE : state_n;

    // frame parser transitions; DONE and ERROR hold until reset
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (fire && bus.BYTE_IN == 8'hA5) state_n = LEN_LO;
            LEN_LO: if (fire) state_n = LEN_HI;
            LEN_HI: if (fire) state_n = 32'(n_hdr) > MAX_WORDS ? ERROR : n_hdr == 16'd0 ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
            DATA:   if (word_end && last) state_n = CHECK;
            CHECK:  if (fire) state_n = bus.BYTE_IN == sum ? DONE : ERROR;
`else
            DATA:   if (bus.MEM_WR && widx == len) state_n = DONE;
`endif
            default: ;
        endcase
    end

    // handshake and boot status decoded from state; reset forces the core into reset at once
    always_comb begin
        bus.BYTE_READY = state != DONE && state != ERROR;
        bus.CORE_RST = RST || state != DONE;
        bus.LOAD_DONE = state == DONE;
        bus.LOAD_ERR = state == ERROR;
    end

    // length capture, little-endian word assembly, write port and word counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcnt <= '0;
            widx <= '0;
            len <= '0;
            asm_q <= '0;
            bus.MEM_WR <= 1'b0;
            bus.MEM_WADDR <= BASE_ADDR;
            bus.MEM_WDATA <= '0;
            bus.WORD_CNT <= '0;
        end else begin
            bus.MEM_WR <= word_end;
            bus.WORD_CNT <= bus.WORD_CNT + 16'(bus.MEM_WR);
            if (fire && state == LEN_LO) len[7:0] <= bus.BYTE_IN;
            if (fire && state == LEN_HI) len[15:8] <= bus.BYTE_IN;
            if (fire && state == DATA) begin
                bcnt <= bcnt + 2'd1;
                asm_q <= {bus.BYTE_IN, asm_q[23:8]};
            end
            if (word_end) begin
                widx <= widx + 16'd1;
                bus.MEM_WADDR <= BASE_ADDR + {46'd0, widx, 2'b00};
                bus.MEM_WDATA <= {bus.BYTE_IN, asm_q};
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // running sum of length and data bytes; the sync byte is excluded
    always_ff @(posedge CLK) begin
        if (RST || state == IDLE) sum <= '0;
        else if (fire && (state == LEN_LO || state == LEN_HI || state == DATA)) sum <= sum + bus.BYTE_IN;
    end
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: table-driven and randomized frames checked against a frame-level model
module tb_instr_mem_loader;
    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int MAXW = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    typedef struct {
        string name;
        int n;
        logic [127:0] w;
        logic [7:0] ck_xor;
        int garb;
        bit thr;
        bit exp_done;
        int exp_wr;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    instr_mem_loader_if bus();
    instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    logic [95:0] got_q[$];
    logic [31:0] words[8];
    vec_t vecs[7];

    always @(negedge CLK) if (bus.MEM_WR) got_q.push_back({bus.MEM_WADDR, bus.MEM_WDATA});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit thr);
        int t = 0;
        if (thr) begin
            bus.BYTE_VALID = 1'b0;
            @(negedge CLK);
        end
        bus.BYTE_IN = b;
        bus.BYTE_VALID = 1'b1;
        while (!bus.BYTE_READY && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.BYTE_READY) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: byte %h never accepted", b);
        end
        @(negedge CLK);
        bus.BYTE_VALID = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] ck_xor, input int ngarb,
                             input bit thr, input bit no_rst, input bit exp_done, input int exp_wr);
        logic [7:0] s, b;
        if (!no_rst) do_reset();
        got_q.delete();
        for (int i = 0; i < ngarb; i++) begin
            b = i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'($urandom_range(0, 164));
            send(b, thr);
        end
        s = 8'(n) + 8'(n >> 8);
        send(8'hA5, thr);
        send(8'(n), thr);
        send(8'(n >> 8), thr);
        if (n <= MAXW) begin
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < 4; j++) begin
                    b = words[k][8*j +: 8];
                    s = s + b;
                    send(b, thr);
                end
                check({tag, "_wr_pulse"}, 64'(bus.MEM_WR), 64'd1);
                check({tag, "_wr_addr"}, bus.MEM_WADDR, BASE + 64'(4 * k));
                check({tag, "_wr_data"}, 64'(bus.MEM_WDATA), 64'(words[k]));
            end
`ifdef LOADER_CHECKSUM_EN
            send(s ^ ck_xor, thr);
            check({tag, "_done_at_ck"}, 64'(bus.LOAD_DONE), 64'(exp_done));
`else
            @(negedge CLK);
            check({tag, "_done_after_wr"}, 64'(bus.LOAD_DONE), 64'(exp_done));
`endif
        end
        repeat (3) @(negedge CLK);
        check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_wr));
        for (int k = 0; k < got_q.size(); k++) begin
            check({tag, "_log_addr"}, got_q[k][95:32], BASE + 64'(4 * k));
            check({tag, "_log_data"}, 64'(got_q[k][31:0]), 64'(words[k]));
        end
        check({tag, "_load_done"}, 64'(bus.LOAD_DONE), 64'(exp_done));
        check({tag, "_load_err"}, 64'(bus.LOAD_ERR), 64'(!exp_done));
        check({tag, "_core_rst"}, 64'(bus.CORE_RST), 64'(!exp_done));
        check({tag, "_ready"}, 64'(bus.BYTE_READY), 64'd0);
        check({tag, "_word_cnt"}, 64'(bus.WORD_CNT), 64'(exp_wr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] x;
        bit ok;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN = 8'h00;
        @(negedge CLK);
        do_reset();
        check("rst_ready", 64'(bus.BYTE_READY), 64'd1);
        check("rst_mem_wr", 64'(bus.MEM_WR), 64'd0);
        check("rst_waddr", bus.MEM_WADDR, BASE);
        check("rst_wdata", 64'(bus.MEM_WDATA), 64'd0);
        check("rst_core_rst", 64'(bus.CORE_RST), 64'd1);
        check("rst_done", 64'(bus.LOAD_DONE), 64'd0);
        check("rst_err", 64'(bus.LOAD_ERR), 64'd0);
        check("rst_word_cnt", 64'(bus.WORD_CNT), 64'd0);

        vecs[0] = '{"image", 2, {64'h0, 32'h00100093, 32'h00000013}, 8'h00, 0, 1'b0, 1'b1, 2};
        vecs[1] = '{"garbage", 1, 128'h12345678, 8'h00, 2, 1'b0, 1'b1, 1};
        vecs[2] = '{"oversize", 5, 128'h0, 8'h00, 0, 1'b0, 1'b0, 0};
        vecs[3] = '{"bad_ck", 2, {64'h0, 32'h00100093, 32'h00000013}, 8'hB8, 0, 1'b0, bit'(!CK), 2};
        vecs[4] = '{"throttled", 2, {64'h0, 32'h00100093, 32'h00000013}, 8'h00, 0, 1'b1, 1'b1, 2};
        vecs[5] = '{"empty", 0, 128'h0, 8'h00, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{"max_wrap", 4, 128'hDEADBEEF_0BADF00D_CAFEBABE_80000001, 8'h00, 1, 1'b0, 1'b1, 4};
        foreach (vecs[i]) begin
            for (int k = 0; k < 4; k++) words[k] = vecs[i].w[32*k +: 32];
            run_frame(vecs[i].name, vecs[i].n, vecs[i].ck_xor, vecs[i].garb, vecs[i].thr, 1'b0,
                      vecs[i].exp_done, vecs[i].exp_wr);
        end

        do_reset();
        got_q.delete();
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        bus.BYTE_IN = 8'hA5;
        bus.BYTE_VALID = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_mem_wr", 64'(bus.MEM_WR), 64'd0);
        check("abort_core_rst", 64'(bus.CORE_RST), 64'd1);
        check("abort_waddr", bus.MEM_WADDR, BASE);
        check("abort_ready", 64'(bus.BYTE_READY), 64'd1);
        check("abort_no_writes", 64'(got_q.size()), 64'd0);
        RST = 1'b0;
        bus.BYTE_VALID = 1'b0;
        run_frame("after_abort", 2, 8'h00, 0, 1'b0, 1'b1, 1'b1, 2);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, MAXW + 1);
            for (int k = 0; k < 8; k++) words[k] = $urandom;
            x = (CK && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            ok = n <= MAXW && x == 8'h00;
            run_frame("random", n, x, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0,
                      ok, n <= MAXW ? n : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
